// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: x/y pixel counters plus sync, visible and
// line/frame strobes, delayed by DELAY pixel-clock-enable cycles to match the renderer.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int CW        = 11,
   parameter int DELAY     = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          visible,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
   localparam logic [CW-1:0] HS_BEGIN = CW'(H_VISIBLE + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_BEGIN = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic          HS_ON    = (HSYNC_POL != 0);
   localparam logic          VS_ON    = (VSYNC_POL != 0);

   if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_cw_too_small
      $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
   end

   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic [4:0]    flags0;
   logic [4:0]    flags_dly;

   // next raster position; line and frame wrap share the same edge
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_en) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
               y_d = '0;
            end else begin
               y_d = y_q + ONE;
            end
         end else begin
            x_d = x_q + ONE;
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // raster counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // stage-0 flags held as "active" bits: {visible, hs, vs, line, frame}
   assign flags0 = {(x_q < H_VIS) && (y_q < V_VIS),
                    (x_q >= HS_BEGIN) && (x_q < HS_END),
                    (y_q >= VS_BEGIN) && (y_q < VS_END),
                    (x_q == '0),
                    (x_q == '0) && (y_q == '0)};

   if (DELAY == 0) begin : g_no_delay
      assign flags_dly = flags0;
   end else begin : g_delay
      logic [4:0] pipe_q [DELAY];

      // pixel-qualified delay line; all-zero is the inactive state of every flag
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
               pipe_q[i] <= 5'b0_0000;
            end
         end else if (pix_en) begin
            pipe_q[0] <= flags0;
            for (int i = 1; i < DELAY; i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end

      assign flags_dly = pipe_q[DELAY-1];
   end

   assign x           = x_q;
   assign y           = y_q;
   assign visible     = flags_dly[4];
   assign hsync       = HS_ON ? flags_dly[3] : ~flags_dly[3];
   assign vsync       = VS_ON ? flags_dly[2] : ~flags_dly[2];
   // gating with pix_en keeps the strobes one clk wide at any pixel rate
   assign line_start  = flags_dly[1] & pix_en;
   assign frame_start = flags_dly[0] & pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four generator configurations compared every cycle against a
// pixel-count based raster model, plus literal spot checks at raster landmarks.
module tb_vga_timing_gen;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb, hpol, vpol, dly;
   } cfg_t;

   localparam cfg_t C_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0};
   localparam cfg_t C_DLY = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
   localparam cfg_t C_SM  = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 0};
   localparam cfg_t C_SMD = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 3};

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pe_a = 1'b0;
   logic pe_b = 1'b0;
   longint n_a = 0;
   longint n_b = 0;
   int checks = 0;
   int failures = 0;

   logic [10:0] a_x, a_y, d_x, d_y;
   logic [3:0]  s_x, s_y, t_x, t_y;
   logic a_hs, a_vs, a_vis, a_ls, a_fs;
   logic d_hs, d_vs, d_vis, d_ls, d_fs;
   logic s_hs, s_vs, s_vis, s_ls, s_fs;
   logic t_hs, t_vs, t_vis, t_ls, t_fs;

   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .pix_en(pe_a), .x(a_x), .y(a_y), .hsync(a_hs), .vsync(a_vs),
      .visible(a_vis), .line_start(a_ls), .frame_start(a_fs));

   vga_timing_gen #(.DELAY(2)) u_dly (
      .clk(clk), .rst(rst), .pix_en(pe_a), .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
      .visible(d_vis), .line_start(d_ls), .frame_start(d_fs));

   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_VISIBLE(4),
      .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .HSYNC_POL(1), .VSYNC_POL(1), .CW(4)) u_small (
      .clk(clk), .rst(rst), .pix_en(pe_b), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
      .visible(s_vis), .line_start(s_ls), .frame_start(s_fs));

   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_VISIBLE(4),
      .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .HSYNC_POL(1), .VSYNC_POL(1), .CW(4),
      .DELAY(3)) u_small_d (
      .clk(clk), .rst(rst), .pix_en(pe_b), .x(t_x), .y(t_y), .hsync(t_hs), .vsync(t_vs),
      .visible(t_vis), .line_start(t_ls), .frame_start(t_fs));

   always #5 clk = ~clk;

   // raster flags of pixel number k since reset: {visible, hs, vs, line, frame}
   function automatic logic [4:0] raw_flags(input cfg_t c, input longint k);
      longint ht, vt, px, py;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      px = k % ht;
      py = (k / ht) % vt;
      return {px < c.hv && py < c.vv,
              px >= c.hv + c.hf && px < c.hv + c.hf + c.hs,
              py >= c.vv + c.vf && py < c.vv + c.vf + c.vs,
              px == 0,
              px == 0 && py == 0};
   endfunction

   function automatic logic [26:0] pk(input int px, input int py, input logic hs, input logic vs,
                                      input logic vis, input logic ls, input logic fs);
      return {px[10:0], py[10:0], hs, vs, vis, ls, fs};
   endfunction

   function automatic logic [26:0] exp_vec(input cfg_t c, input longint n, input logic pe);
      longint ht, vt;
      logic [4:0] f;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      f = (n >= c.dly) ? raw_flags(c, n - c.dly) : 5'b0_0000;
      return pk(int'(n % ht), int'((n / ht) % vt),
                (c.hpol != 0) ? f[3] : ~f[3], (c.vpol != 0) ? f[2] : ~f[2],
                f[4], f[1] & pe, f[0] & pe);
   endfunction

   task automatic cmp(input string name, input logic [26:0] act, input logic [26:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // pixel counts since reset, one per instance group
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_a <= 0;
         n_b <= 0;
      end else begin
         if (pe_a) n_a <= n_a + 1;
         if (pe_b) n_b <= n_b + 1;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      cmp("def", pk(int'(a_x), int'(a_y), a_hs, a_vs, a_vis, a_ls, a_fs), exp_vec(C_DEF, n_a, pe_a));
      cmp("dly", pk(int'(d_x), int'(d_y), d_hs, d_vs, d_vis, d_ls, d_fs), exp_vec(C_DLY, n_a, pe_a));
      cmp("small", pk(int'(s_x), int'(s_y), s_hs, s_vs, s_vis, s_ls, s_fs), exp_vec(C_SM, n_b, pe_b));
      cmp("small_d", pk(int'(t_x), int'(t_y), t_hs, t_vs, t_vis, t_ls, t_fs), exp_vec(C_SMD, n_b, pe_b));
   end

   initial begin
      logic [4:0] f;

      // model pins
      f = raw_flags(C_DEF, 656);         cmp("pin_hs656", 27'(f[3]), 27'd1);
      f = raw_flags(C_DEF, 752);         cmp("pin_hs752", 27'(f[3]), 27'd0);
      f = raw_flags(C_DEF, 639);         cmp("pin_vis639", 27'(f[4]), 27'd1);
      f = raw_flags(C_DEF, 640);         cmp("pin_vis640", 27'(f[4]), 27'd0);
      f = raw_flags(C_DEF, 800 * 490);   cmp("pin_vs490", 27'(f[2]), 27'd1);
      f = raw_flags(C_DEF, 800 * 492);   cmp("pin_vs492", 27'(f[2]), 27'd0);
      f = raw_flags(C_DEF, 800 * 525);   cmp("pin_fwrap", 27'(f[0]), 27'd1);
      f = raw_flags(C_SM, 11);           cmp("pin_sm_hs11", 27'(f[3]), 27'd1);
      f = raw_flags(C_SM, 14 * 7);       cmp("pin_sm_fwrap", 27'(f[0]), 27'd1);

      pe_a = 1'b1;
      pe_b = 1'b1;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // continuous pixel rate with literal landmarks
      for (int k = 1; k <= 1700; k++) begin
         @(posedge clk);
         #2;
         if (k == 655) cmp("def_hs655", 27'(a_hs), 27'd1);
         if (k == 656) cmp("def_hs656", pk(int'(a_x), 0, a_hs, 1'b0, 1'b0, 1'b0, 1'b0), pk(656, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         if (k == 752) cmp("def_hs752", 27'(a_hs), 27'd1);
         if (k == 800) cmp("def_line1", pk(int'(a_x), int'(a_y), 1'b0, 1'b0, 1'b0, a_ls, 1'b0), pk(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
         if (k == 1)   cmp("dly_vis1", 27'(d_vis), 27'd0);
         if (k == 2)   cmp("dly_vis2", 27'({d_vis, d_fs}), 27'd3);
         if (k == 641) cmp("dly_vis641", 27'(d_vis), 27'd1);
         if (k == 642) cmp("dly_vis642", 27'(d_vis), 27'd0);
         if (k == 657) cmp("dly_hs657", 27'(d_hs), 27'd1);
         if (k == 658) cmp("dly_hs658", 27'(d_hs), 27'd0);
         if (k == 13)  cmp("sm_x13", pk(int'(s_x), int'(s_y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), pk(13, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         if (k == 14)  cmp("sm_wrap_x", pk(int'(s_x), int'(s_y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), pk(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         if (k == 97)  cmp("sm_last", pk(int'(s_x), int'(s_y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), pk(13, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         if (k == 98)  cmp("sm_fwrap", pk(int'(s_x), int'(s_y), 1'b0, 1'b0, 1'b0, 1'b0, s_fs), pk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
         if (k == 10)  cmp("sm_hs10", 27'(s_hs), 27'd1);
         if (k == 12)  cmp("sm_hs12", 27'(s_hs), 27'd0);
         if (k == 70)  cmp("sm_vs70", 27'(s_vs), 27'd1);
         if (k == 84)  cmp("sm_vs84", 27'(s_vs), 27'd0);
      end

      // asynchronous reset mid-cycle
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      cmp("arst_xy", pk(int'(a_x), int'(a_y), a_hs, a_vs, 1'b0, 1'b0, 1'b0), pk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      cmp("arst_small", 27'({s_hs, s_vs, d_vis}), 27'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      cmp("arst_fs", 27'({a_fs, d_fs}), 27'd2);

      // one-in-four pixel rate, then random rates with occasional async resets
      for (int i = 0; i < 14000; i++) begin
         @(posedge clk);
         #1;
         rst = 1'b0;
         if (i < 4000) begin
            pe_a = (i % 4 == 0);
            pe_b = (i % 4 == 0);
         end else begin
            pe_a = ($urandom_range(0, 3) != 0);
            pe_b = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 499) == 0) begin
               #2 rst = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
